// File: rtl/multi_button_debounce.sv
// multi_button_debounce
// N_CH independent push-button channels. Each raw pin is polarity-corrected,
// passed through a 2-flop synchroniser and qualified by a 4-state debounce
// FSM that needs DEBOUNCE_CYCLES consecutive stable cycles before accepting
// a level change. Outputs are a debounced level, one-cycle press/release
// pulses and a wrapping per-channel press counter.
//
// Optional feature: define DEBOUNCE_REPEAT_EN to add auto-repeat press
// pulses while a button is held (first after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles). Without the macro no repeat logic exists.
module multi_button_debounce #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 600000,
    parameter int CNT_W           = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         btn_raw,
    output logic [N_CH-1:0]         btn_level,
    output logic [N_CH-1:0]         press_pulse,
    output logic [N_CH-1:0]         release_pulse,
    output logic [N_CH*CNT_W-1:0]   press_count
);

    localparam int                STAB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

`ifdef DEBOUNCE_REPEAT_EN
    localparam int               RPT_MAX         = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W           = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
`endif

    // Reject out-of-range configurations at elaboration time
    if (N_CH < 1 || N_CH > 8 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 1048575 ||
        CNT_W < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("multi_button_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    // Polarity is corrected at the pin so the synchroniser holds "pressed"
    // bits; its reset value of 0 then means "released", which forces a
    // button still held across reset to be re-qualified with full latency.
    // A single inverter per bit cannot create a multi-bit sampling hazard.
    logic [N_CH-1:0] pin_pressed_s;
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    assign pin_pressed_s = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_pressed_s;
            sync2_q <= sync1_q;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t            state_q;
        logic [STAB_W-1:0] stab_q;
        logic              level_q;
        logic              press_q;
        logic              release_q;
        logic [CNT_W-1:0]  count_q;
        logic              lvl_s;

        assign lvl_s = sync2_q[c];

`ifdef DEBOUNCE_REPEAT_EN
        logic [RPT_W-1:0] rpt_q;
        logic             rpt_periodic_q;
        logic             rpt_adv_s;
        logic             rpt_hold_s;
        logic             rpt_hit_s;

        // Repeat timer advances on every stable-pressed cycle, freezes while
        // a release is being qualified and clears once the channel is released
        always_comb begin
            rpt_adv_s  = 1'b0;
            rpt_hold_s = 1'b0;
            rpt_hit_s  = 1'b0;
            if (state_q == ST_PRESSED || state_q == ST_RELEASE_WAIT) begin
                rpt_adv_s  = lvl_s;
                rpt_hold_s = ~lvl_s;
            end else begin
                rpt_adv_s  = 1'b0;
                rpt_hold_s = 1'b0;
            end
            if (rpt_periodic_q) begin
                rpt_hit_s = (rpt_q == RPT_PERIOD_LAST);
            end else begin
                rpt_hit_s = (rpt_q == RPT_DELAY_LAST);
            end
        end
`endif

        // Debounce FSM with registered level, pulses and press counter
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                stab_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                count_q   <= '0;
`ifdef DEBOUNCE_REPEAT_EN
                rpt_q          <= '0;
                rpt_periodic_q <= 1'b0;
`endif
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        stab_q <= '0;
                        if (lvl_s) begin
                            state_q <= ST_PRESS_WAIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_PRESS_WAIT: begin
                        if (!lvl_s) begin
                            state_q <= ST_IDLE;
                            stab_q  <= '0;
                        end else if (stab_q == STAB_LAST) begin
                            state_q <= ST_PRESSED;
                            stab_q  <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                            count_q <= count_q + CNT_ONE;
                        end else begin
                            stab_q <= stab_q + STAB_ONE;
                        end
                    end
                    ST_PRESSED: begin
                        stab_q <= '0;
                        if (!lvl_s) begin
                            state_q <= ST_RELEASE_WAIT;
                        end else begin
                            state_q <= ST_PRESSED;
                        end
                    end
                    ST_RELEASE_WAIT: begin
                        if (lvl_s) begin
                            state_q <= ST_PRESSED;
                            stab_q  <= '0;
                        end else if (stab_q == STAB_LAST) begin
                            state_q   <= ST_IDLE;
                            stab_q    <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            stab_q <= stab_q + STAB_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        stab_q  <= '0;
                        level_q <= 1'b0;
                    end
                endcase
`ifdef DEBOUNCE_REPEAT_EN
                if (rpt_adv_s) begin
                    if (rpt_hit_s) begin
                        press_q        <= 1'b1;
                        rpt_q          <= '0;
                        rpt_periodic_q <= 1'b1;
                    end else begin
                        rpt_q <= rpt_q + RPT_ONE;
                    end
                end else if (rpt_hold_s) begin
                    rpt_q          <= rpt_q;
                    rpt_periodic_q <= rpt_periodic_q;
                end else begin
                    rpt_q          <= '0;
                    rpt_periodic_q <= 1'b0;
                end
`endif
            end
        end

        assign btn_level[c]                   = level_q;
        assign press_pulse[c]                 = press_q;
        assign release_pulse[c]               = release_q;
        assign press_count[c*CNT_W +: CNT_W]  = count_q;
    end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Self-checking bench for multi_button_debounce (N_CH=2, DEBOUNCE_CYCLES=4,
// CNT_W=2, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=5). The reference
// model counts consecutive samples that disagree with the accepted state.
module tb_multi_button_debounce;

    localparam int N_CH = 2;
    localparam int DEB  = 4;
    localparam int CW   = 2;
    localparam int RD   = 10;
    localparam int RP   = 5;

    logic       clk;
    logic       rst;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [3:0] press_count;

    int checks;
    int errors;

    // reference model state
    logic [1:0] m_p1, m_p2, m_acc, m_pp, m_rp;
    int         m_run [2];
    int         m_cnt [2];
    int         m_t   [2];

    multi_button_debounce #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .ACTIVE_LOW(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_count();
        logic [31:0] a;
        logic [31:0] b;
        a = m_cnt[1];
        b = m_cnt[0];
        return {a[1:0], b[1:0]};
    endfunction

    // Model: pins are seen two edges late; a level change is accepted once
    // DEB+1 consecutive samples disagree with the accepted state.
    task automatic model_step();
        if (rst) begin
            m_p1 = 2'b00; m_p2 = 2'b00; m_acc = 2'b00; m_pp = 2'b00; m_rp = 2'b00;
            for (int c = 0; c < 2; c++) begin
                m_run[c] = 0; m_cnt[c] = 0; m_t[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_pp[c] = 1'b0;
                m_rp[c] = 1'b0;
                if (m_p2[c] != m_acc[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB + 1) begin
                        m_acc[c] = m_p2[c];
                        m_run[c] = 0;
                        if (m_acc[c]) begin
                            m_pp[c]  = 1'b1;
                            m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
                            m_t[c]   = 0;
                        end else begin
                            m_rp[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
`ifdef DEBOUNCE_REPEAT_EN
                    if (m_acc[c]) begin
                        m_t[c]++;
                        if (m_t[c] == RD || (m_t[c] > RD && (m_t[c] - RD) % RP == 0))
                            m_pp[c] = 1'b1;
                    end
`endif
                end
            end
            m_p2 = m_p1;
            m_p1 = ~btn_raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_raw = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b required 0", {btn_level, press_pulse, release_pulse, press_count});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL reset_idle: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
        end
    endtask

    task automatic test_single_press();
        int first;
        int presses;
        int releases;
        do_reset();
        btn_raw = 2'b11;
        tick();
        btn_raw[0] = 1'b0;
        first = -1; presses = 0; releases = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL press_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (btn_level[0] && first < 0) first = i;
            if (press_pulse[0]) presses++;
        end
        checks++;
        if (first !== 7) begin
            errors++;
            $display("FAIL press_latency: level rose in cycle %0d required 7", first);
        end
        checks++;
        if (presses !== 1 || press_count[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL press_pulse_count: pulses %0d count %0d required 1 and 1", presses, press_count[1:0]);
        end
        btn_raw[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL release_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (release_pulse[0]) releases++;
        end
        checks++;
        if (releases !== 1 || btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_once: releases %0d level %b required 1 and 0", releases, btn_level[0]);
        end
    endtask

    task automatic test_glitch();
        int bad;
        do_reset();
        btn_raw = 2'b11;
        tick();
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            btn_raw[0] = (i < 3) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL glitch_idle_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (btn_level[0] || press_pulse[0] || press_count[1:0] != 2'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch_press: %0d cycles with output change required 0", bad);
        end
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            btn_raw[0] = (i < 3) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL glitch_held_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (release_pulse[0] || !btn_level[0]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL glitch_release: %0d cycles with release activity required 0", bad);
        end
    endtask

    task automatic test_count_wrap();
        logic [1:0] seq [4];
        int releases;
        do_reset();
        btn_raw = 2'b11;
        tick();
        releases = 0;
        for (int p = 0; p < 4; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                int h;
                btn_raw[0] = (ph == 0) ? 1'b0 : 1'b1;
                h = $urandom_range(8, 14);
                for (int i = 0; i < h; i++) begin
                    tick();
                    checks++;
                    if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                        errors++;
                        $display("FAIL wrap_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
                    end
                    if (release_pulse[0]) releases++;
                end
                if (ph == 0) seq[p] = press_count[1:0];
            end
        end
        checks++;
        if (seq[0] !== 2'd1 || seq[1] !== 2'd2 || seq[2] !== 2'd3 || seq[3] !== 2'd0) begin
            errors++;
            $display("FAIL wrap_sequence: got %0d,%0d,%0d,%0d required 1,2,3,0", seq[0], seq[1], seq[2], seq[3]);
        end
        checks++;
        if (releases !== 4 || press_count[3:2] !== 2'd0) begin
            errors++;
            $display("FAIL wrap_release_ch1: releases %0d ch1 count %0d required 4 and 0", releases, press_count[3:2]);
        end
    endtask

    task automatic test_simultaneous();
        int both;
        int single;
        do_reset();
        btn_raw = 2'b11;
        tick();
        btn_raw = 2'b00;
        both = 0; single = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL simul_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (press_pulse == 2'b11) both++;
            if (press_pulse == 2'b01 || press_pulse == 2'b10) single++;
        end
        checks++;
        if (both !== 1 || single !== 0 || press_count !== 4'b0101) begin
            errors++;
            $display("FAIL simul_pulses: both %0d single %0d counts %b required 1, 0, 0101", both, single, press_count);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        int bad;
        do_reset();
        btn_raw = 2'b11;
        tick();
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL rstmid_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (press_pulse != 2'b00 || btn_level != 2'b00) bad++;
        end
        rst = 1'b0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL rstmid_after_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (press_pulse[0] && first < 0) first = i;
        end
        checks++;
        if (bad !== 0 || first !== 7 || press_count[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL rstmid_requalify: bad %0d first %0d count %0d required 0, 7, 1", bad, first, press_count[1:0]);
        end
    endtask

    task automatic test_repeat();
        logic [29:0] seen;
        logic [29:0] want;
        logic        found;
        do_reset();
        btn_raw = 2'b11;
        tick();
        btn_raw[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL repeat_wait_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            if (press_pulse[0]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL repeat_accept_timeout: got no press in 20 cycles required one");
        end
        seen = 30'b1;
        want = 30'b1;
`ifdef DEBOUNCE_REPEAT_EN
        want[10] = 1'b1; want[15] = 1'b1; want[20] = 1'b1; want[25] = 1'b1;
`endif
        for (int j = 1; j < 30; j++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL repeat_model: got %b required %b", {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            seen[j] = press_pulse[0];
        end
        checks++;
        if (seen !== want || press_count[1:0] !== 2'd1) begin
            errors++;
            $display("FAIL repeat_offsets: got %b count %0d required %b count 1", seen, press_count[1:0], want);
        end
    endtask

    task automatic test_random();
        int hold [2];
        do_reset();
        btn_raw = 2'b11;
        hold[0] = 0;
        hold[1] = 0;
        for (int i = 0; i < 1500; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, press_count} !== {m_acc, m_pp, m_rp, exp_count()}) begin
                errors++;
                $display("FAIL random_model: cycle %0d got %b required %b", i, {btn_level, press_pulse, release_pulse, press_count}, {m_acc, m_pp, m_rp, exp_count()});
            end
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(0, 1));
                    hold[c]    = $urandom_range(1, 9);
                end
                hold[c]--;
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        btn_raw = 2'b11;
        test_reset();
        test_single_press();
        test_glitch();
        test_count_wrap();
        test_simultaneous();
        test_reset_mid();
        test_repeat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
